// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes, access size,
// pipe control word and the lane-select / extension helpers also used by forwarding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    typedef struct packed {
        logic       valid;
        logic       fault;
        logic       load;
        logic [2:0] funct3;
        logic [1:0] off;
    } pipe_ctl_t;

    function automatic size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            2'b10:   return SZ_W;
            default: return SZ_BAD;
        endcase
    endfunction

    // Moves the addressed byte/half down to bit 0.
    function automatic logic [31:0] lane_select(input logic [31:0] word, input logic [1:0] off);
        return word >> {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] lane, input logic [2:0] funct3);
        case (funct3)
            F3_B:    return {{24{lane[7]}}, lane[7:0]};
            F3_H:    return {{16{lane[15]}}, lane[15:0]};
            F3_W:    return lane;
            F3_BU:   return {24'h000000, lane[7:0]};
            F3_HU:   return {16'h0000, lane[15:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Response FIFO holding {fault, rdata} entries that could not be handed straight
// to the response port.
module dmem_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        else return p + PW'(1);
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32 data memory with LSU front end: decode/fault check, byte-enable
// RAM, READ_LAT control pipe, response FIFO with bypass and outstanding-request credit.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1,
    parameter int RSP_DEPTH   = 2,
    parameter     INIT_FILE   = "",
    localparam int AW = $clog2(DEPTH_WORDS) + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_fault
);
    localparam int WW = AW - 2;
    localparam int OW = $clog2(RSP_DEPTH + 1);

    logic          accept_s;
    logic          rsp_hs_s;
    size_e         size_s;
    logic          illegal_s;
    logic          misalign_s;
    logic          fault_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [WW-1:0] widx_s;
    logic [1:0]    off_s;
    pipe_ctl_t     stage_in_s;
    pipe_ctl_t     fin_s;
    logic [31:0]   fin_data_s;
    logic [32:0]   fin_entry_s;
    logic [32:0]   fifo_head_s;
    logic [32:0]   rsp_entry_s;
    logic          rsp_valid_s;
    logic          fifo_empty_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic [OW-1:0] out_next_s;

    logic [31:0]   mem_r  [DEPTH_WORDS];
    pipe_ctl_t     ctl_r  [READ_LAT];
    logic [31:0]   word_r [READ_LAT];
    logic [OW-1:0] out_r;
    logic          ready_r;

    assign widx_s    = req_addr[AW-1:2];
    assign off_s     = req_addr[1:0];
    assign accept_s  = req_valid && ready_r;
    assign req_ready = ready_r;

    // Request decode: legality, alignment, byte enables and lane-replicated store data.
    always_comb begin
        size_s = size_of(req_funct3);
        if (req_we) illegal_s = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
        else illegal_s = (size_s == SZ_BAD) || (req_funct3 == 3'b110);
        misalign_s = ((size_s == SZ_H) && off_s[0]) || ((size_s == SZ_W) && (off_s != 2'b00));
        fault_s    = illegal_s || misalign_s;
        be_s       = 4'b0000;
        wdata_s    = req_wdata;
        case (size_s)
            SZ_B: begin
                be_s    = 4'b0001 << off_s;
                wdata_s = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be_s    = 4'b0011 << off_s;
                wdata_s = {2{req_wdata[15:0]}};
            end
            SZ_W:    be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
    end

    // Control word entering the pipe; all-zero when nothing is accepted.
    always_comb begin
        stage_in_s = '0;
        if (accept_s) begin
            stage_in_s.valid  = 1'b1;
            stage_in_s.fault  = fault_s;
            stage_in_s.load   = !req_we;
            stage_in_s.funct3 = req_funct3;
            stage_in_s.off    = off_s;
        end else begin
            stage_in_s = '0;
        end
    end

    // RAM write and read on the acceptance edge; read word travels alongside the control pipe.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (req_we && !fault_s) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[b]) mem_r[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
            word_r[0] <= mem_r[widx_s];
        end
        for (int i = 1; i < READ_LAT; i++) word_r[i] <= word_r[i-1];
    end

    // Outstanding-request credit: accept adds one, response handshake removes one.
    always_comb begin
        case ({accept_s, rsp_hs_s})
            2'b10:   out_next_s = out_r + OW'(1);
            2'b01:   out_next_s = out_r - OW'(1);
            default: out_next_s = out_r;
        endcase
    end

    // Control pipe, credit counter and registered request-ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) ctl_r[i] <= '0;
            out_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            ctl_r[0] <= stage_in_s;
            for (int i = 1; i < READ_LAT; i++) ctl_r[i] <= ctl_r[i-1];
            out_r   <= out_next_s;
            ready_r <= (out_next_s < OW'(RSP_DEPTH));
        end
    end

    // Final stage: extend, then bypass to the port when the FIFO is empty, else queue behind it.
    always_comb begin
        fin_s = ctl_r[READ_LAT-1];
        if (fin_s.load && !fin_s.fault) begin
            fin_data_s = load_extend(lane_select(word_r[READ_LAT-1], fin_s.off), fin_s.funct3);
        end else begin
            fin_data_s = 32'h0000_0000;
        end
        fin_entry_s = {fin_s.fault, fin_data_s};
        if (fifo_empty_s) rsp_entry_s = fin_entry_s;
        else rsp_entry_s = fifo_head_s;
        rsp_valid_s = !fifo_empty_s || fin_s.valid;
        rsp_hs_s    = rsp_valid_s && rsp_ready;
        fifo_pop_s  = !fifo_empty_s && rsp_ready;
        fifo_push_s = fin_s.valid && !(fifo_empty_s && rsp_ready);
    end

    dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (33)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data (fin_entry_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s)
    );

    assign rsp_valid = rsp_valid_s;
    assign rsp_fault = rsp_entry_s[32];
    assign rsp_rdata = rsp_entry_s[31:0];

endmodule
